// File: rtl/fifo_arb_tx.sv
// Transmit-side packet arbiter: merges two client FIFO packet streams into one
// output FIFO, one whole packet at a time, optionally tagging headers by source.
module fifo_arb_tx #(
    parameter int                DWIDTH  = 8,
    parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
    parameter logic [DWIDTH-1:0] CNTMASK = 8'h70,
    parameter bit                TAG_EN  = 1'b1
) (
    input  logic              CLK,
    input  logic              RESETn,
    output logic              c1_rden,
    input  logic              c1_rdempty,
    input  logic [DWIDTH-1:0] c1_rddata,
    output logic              c2_rden,
    input  logic              c2_rdempty,
    input  logic [DWIDTH-1:0] c2_rddata,
    output logic              fifo_wren,
    input  logic              fifo_wrfull,
    output logic [DWIDTH-1:0] fifo_wrdata,
    output logic              busy
);

    function automatic int lowest_bit(input logic [DWIDTH-1:0] m);
        int r;
        r = 0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    localparam int CSHIFT = lowest_bit(CNTMASK);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t            state_reg;
    logic              gnt_reg;      // 0 = c1, 1 = c2
    logic              last_reg;
    logic              rd_vld_reg;
    logic              rd_hdr_reg;
    logic              hold_vld_reg;
    logic [DWIDTH-1:0] hold_reg;
    logic [3:0]        rem_reg;

    logic              idle_pick;
    logic              sel;
    logic              sel_empty;
    logic              state_ok;
    logic              rd_go;
    logic [DWIDTH-1:0] rd_raw;
    logic [DWIDTH-1:0] rd_tag;
    logic [2:0]        hdr_code;
    logic [3:0]        hdr_len;

    // In IDLE the grant is chosen this cycle; ties go to the client not served last.
    always_comb begin
        if (!c1_rdempty && !c2_rdempty) idle_pick = ~last_reg;
        else                            idle_pick = c1_rdempty;
    end

    assign sel       = (state_reg == IDLE) ? idle_pick : gnt_reg;
    assign sel_empty = sel ? c2_rdempty : c1_rdempty;
    assign state_ok  = (state_reg == IDLE) || ((state_reg == PAY) && (rem_reg != 4'd0));
    assign rd_go     = RESETn & state_ok & ~sel_empty & ~fifo_wrfull & ~hold_vld_reg;
    assign c1_rden   = rd_go & ~sel;
    assign c2_rden   = rd_go & sel;

    assign rd_raw = gnt_reg ? c2_rddata : c1_rddata;

    always_comb begin
        rd_tag = rd_raw;
        if (TAG_EN && rd_hdr_reg) begin
            rd_tag = gnt_reg ? (rd_raw & ~SELMASK) : (rd_raw | SELMASK);
        end
    end

    // Length decode works on the untagged header.
    assign hdr_code = rd_raw[CSHIFT +: 3];
    always_comb begin
        case (hdr_code)
            3'd1:    hdr_len = 4'd1;
            3'd2:    hdr_len = 4'd2;
            3'd3:    hdr_len = 4'd4;
            3'd4:    hdr_len = 4'd8;
            default: hdr_len = 4'd0;
        endcase
    end

    assign fifo_wrdata = hold_vld_reg ? hold_reg : rd_tag;
    assign fifo_wren   = RESETn & (hold_vld_reg | rd_vld_reg) & ~fifo_wrfull;
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_reg    <= IDLE;
            gnt_reg      <= 1'b0;
            last_reg     <= 1'b1;
            rd_vld_reg   <= 1'b0;
            rd_hdr_reg   <= 1'b0;
            hold_vld_reg <= 1'b0;
            hold_reg     <= '0;
            rem_reg      <= 4'd0;
        end else begin
            rd_vld_reg <= rd_go;
            rd_hdr_reg <= rd_go & (state_reg == IDLE);

            // Skid: a returning byte that meets a full output is parked for later.
            if (rd_vld_reg && fifo_wrfull) begin
                hold_reg     <= rd_tag;
                hold_vld_reg <= 1'b1;
            end else if (hold_vld_reg && !fifo_wrfull) begin
                hold_vld_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (rd_go) begin
                        gnt_reg   <= sel;
                        last_reg  <= sel;
                        state_reg <= HDR;
                    end
                end
                HDR: begin
                    if (rd_vld_reg) begin
                        if (hdr_len == 4'd0) begin
                            state_reg <= IDLE;
                        end else begin
                            rem_reg   <= hdr_len;
                            state_reg <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (rd_go) begin
                        rem_reg <= rem_reg - 4'd1;
                        if (rem_reg == 4'd1) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Scoreboard bench for fifo_arb_tx: client FIFOs are modelled as arrays with
// read/write counters; expected output bytes are queued by the stimulus.
module tb_fifo_arb_tx;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       c1_rden, c2_rden;
    logic       c1_rdempty, c2_rdempty;
    logic [7:0] c1_rddata = 8'h00;
    logic [7:0] c2_rddata = 8'h00;
    logic       fifo_wren;
    logic       fifo_wrfull = 1'b0;
    logic [7:0] fifo_wrdata;
    logic       busy;

    logic [7:0] c1_mem [0:255];
    logic [7:0] c2_mem [0:255];
    int         c1_pushed = 0, c1_popped = 0;
    int         c2_pushed = 0, c2_popped = 0;
    logic       flush = 1'b0;
    logic       mon_ignore = 1'b0;

    logic [7:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         wr_seen = 0;
    int         exp_total = 0;

    fifo_arb_tx dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .c1_rden     (c1_rden),
        .c1_rdempty  (c1_rdempty),
        .c1_rddata   (c1_rddata),
        .c2_rden     (c2_rden),
        .c2_rdempty  (c2_rdempty),
        .c2_rddata   (c2_rddata),
        .fifo_wren   (fifo_wren),
        .fifo_wrfull (fifo_wrfull),
        .fifo_wrdata (fifo_wrdata),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    assign c1_rdempty = (c1_pushed == c1_popped);
    assign c2_rdempty = (c2_pushed == c2_popped);

    // Client FIFO models: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (flush) begin
            c1_popped <= c1_pushed;
            c2_popped <= c2_pushed;
        end else begin
            if (c1_rden && !c1_rdempty) begin
                c1_rddata <= c1_mem[c1_popped];
                c1_popped <= c1_popped + 1;
            end
            if (c2_rden && !c2_rdempty) begin
                c2_rddata <= c2_mem[c2_popped];
                c2_popped <= c2_popped + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (c1_rden || c2_rden) begin
                chk("single_rden", {31'd0, c1_rden & c2_rden}, 32'd0);
                chk("rden_on_empty", {31'd0, (c1_rden & c1_rdempty) | (c2_rden & c2_rdempty)}, 32'd0);
            end
            if (fifo_wren) begin
                chk("wren_while_full", {31'd0, fifo_wrfull}, 32'd0);
                if (!mon_ignore) begin
                    wr_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {24'd0, fifo_wrdata}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        chk("wrdata", {24'd0, fifo_wrdata}, {24'd0, e});
                        $display("[TB] write 0x%02h expected 0x%02h", fifo_wrdata, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push1(input logic [7:0] b);
        c1_mem[c1_pushed] = b;
        c1_pushed++;
    endtask

    task automatic push2(input logic [7:0] b);
        c2_mem[c2_pushed] = b;
        c2_pushed++;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_total++;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !busy && c1_rdempty && c2_rdempty) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (busy == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_outputs", {28'd0, c1_rden, c2_rden, fifo_wren, busy}, 32'd0);
        tick();
        RESETn = 1'b1;
        repeat (2) tick();

        // Code-0 header from c1 gets SELMASK set
        push1(8'h02);
        expect_byte(8'h82);
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        chk("t1_c2_untouched", c2_popped, 0);
        wait_drain("t1_drain");

        // c2 stream: SELMASK cleared on headers, payload passes through
        push2(8'h93); push2(8'h0A); push2(8'h0B); push2(8'h0C); push2(8'h0D);
        expect_byte(8'h13); expect_byte(8'h0A);
        expect_byte(8'h0B); expect_byte(8'h0C); expect_byte(8'h0D);
        wait_drain("t2_drain");

        // Round robin, three code-3 packets per client
        for (int k = 0; k < 3; k++) begin
            push1(8'h30);
            for (int j = 0; j < 4; j++) push1(8'(8'h40 + k * 4 + j));
            push2(8'hB5);
            for (int j = 0; j < 4; j++) push2(8'(8'h60 + k * 4 + j));
        end
        for (int k = 0; k < 3; k++) begin
            expect_byte(8'hB0);
            for (int j = 0; j < 4; j++) expect_byte(8'(8'h40 + k * 4 + j));
            expect_byte(8'h35);
            for (int j = 0; j < 4; j++) expect_byte(8'(8'h60 + k * 4 + j));
        end
        wait_drain("t3_drain");

        // Code-4 packet against a toggling full flag
        push1(8'h40);
        for (int j = 0; j < 8; j++) push1(8'(8'hA0 + j));
        expect_byte(8'hC0);
        for (int j = 0; j < 8; j++) expect_byte(8'(8'hA0 + j));
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            tick();
            fifo_wrfull = ~fifo_wrfull;
        end
        fifo_wrfull = 1'b0;
        wait_drain("t4_drain");

        // c1 stalls mid-packet; c2 must wait for the rest of c1's payload
        push1(8'h40); push1(8'hB0); push1(8'hB1);
        wait_busy(1'b1, "t5_c1_grant");
        push2(8'h05);
        expect_byte(8'hC0); expect_byte(8'hB0); expect_byte(8'hB1);
        repeat (20) tick();
        chk("t5_c2_waiting", c2_popped, c2_pushed - 1);
        for (int j = 2; j < 8; j++) begin
            push1(8'(8'hB0 + j));
            expect_byte(8'(8'hB0 + j));
        end
        expect_byte(8'h05);
        wait_drain("t5_drain");

        // Reset mid-payload, then tie break and reserved code
        mon_ignore = 1'b1;
        push1(8'h40);
        for (int j = 0; j < 8; j++) push1(8'(8'hE0 + j));
        repeat (5) tick();
        chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        RESETn = 1'b0;
        flush = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_rst_outputs", {28'd0, c1_rden, c2_rden, fifo_wren, busy}, 32'd0);
        tick();
        flush = 1'b0;
        RESETn = 1'b1;
        mon_ignore = 1'b0;
        tick();
        push1(8'h60);
        push2(8'h01);
        expect_byte(8'hE0);
        expect_byte(8'h01);
        wait_drain("t6_drain");

        chk("write_count", wr_seen, exp_total);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
